// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
//
// Configurable UART transmitter: 5..8 data bits, none/even/odd parity,
// one or two stop bits, eight selectable baud rates, valid/ready input
// handshake. All frame settings are captured together with the payload at
// the handshake, so later changes on the config inputs only affect the next
// frame.
//
// Parameters
//   CLK_FREQ    : Clk frequency in Hz; baud divisors are CLK_FREQ / baud.
//   IDLE_LEVEL  : line level when idle and during stop bits.
//
// Ports
//   Clk         : system clock, rising edge.
//   Reset       : asynchronous, active-high reset.
//   Data        : payload; only bits [Data_bits+4:0] are sent.
//   Tx_valid    : source presents a byte on Data.
//   Tx_ready    : block accepts a byte this cycle (IDLE and not in reset).
//   Baud_set    : 0=9600 1=19200 2=38400 3=57600 4=115200 5=230400
//                 6=460800 7=921600.
//   Data_bits   : payload width minus 5.
//   Parity_mode : 0=none 1=even 2=odd 3=none.
//   Stop_bits   : 0=one stop bit, 1=two.
//   uart_tx     : serial line.
//   Tx_busy     : high while a frame is on the line.
//   Tx_done     : one-cycle pulse in the first idle cycle after a frame.
// ---------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Data,
    input  logic       Tx_valid,
    output logic       Tx_ready,
    input  logic [2:0] Baud_set,
    input  logic [1:0] Data_bits,
    input  logic [1:0] Parity_mode,
    input  logic       Stop_bits,
    output logic       uart_tx,
    output logic       Tx_busy,
    output logic       Tx_done
);

    // The slowest rate sets the counter width; it only needs to reach DIV-1.
    localparam int unsigned DIV_MAX = CLK_FREQ / 9600;
    localparam int          CW      = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Terminal count (DIV-1) for a baud select.
    function automatic logic [CW-1:0] div_m1_of(input logic [2:0] sel);
        int unsigned d;
        case (sel)
            3'd0:    d = CLK_FREQ / 9600;
            3'd1:    d = CLK_FREQ / 19200;
            3'd2:    d = CLK_FREQ / 38400;
            3'd3:    d = CLK_FREQ / 57600;
            3'd4:    d = CLK_FREQ / 115200;
            3'd5:    d = CLK_FREQ / 230400;
            3'd6:    d = CLK_FREQ / 460800;
            default: d = CLK_FREQ / 921600;
        endcase
        return CW'(d - 1);
    endfunction

    state_t        state, next_state;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] div_m1;
    logic [2:0]    bit_cnt;
    logic [2:0]    last_bit;    // index of the final payload bit
    logic [7:0]    data_q;
    logic          parity_q;    // precomputed parity line value
    logic          par_en;
    logic          two_stop;
    logic          done_q;

    logic          handshake;
    logic          bit_end;
    logic          done_set;
    logic          tx_line;
    logic [7:0]    payload_mask;

    assign handshake    = Tx_valid && Tx_ready;
    assign bit_end      = (baud_cnt == div_m1);
    // Clears the unsent upper bits so they never reach the parity.
    assign payload_mask = 8'hFF >> (2'd3 - Data_bits);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= next_state;
        end
    end

    // Next-state and line decode.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        tx_line    = IDLE_LEVEL;
        done_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (handshake) next_state = S_START;
            end
            S_START: begin
                tx_line = ~IDLE_LEVEL;
                if (bit_end) next_state = S_DATA;
            end
            S_DATA: begin
                tx_line = data_q[bit_cnt];
                if (bit_end && (bit_cnt == last_bit))
                    next_state = par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_line = parity_q;
                if (bit_end) next_state = S_STOP;
            end
            S_STOP: begin
                tx_line = IDLE_LEVEL;
                if (bit_end && (!two_stop || bit_cnt[0])) begin
                    next_state = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: baud/bit counters and the per-frame configuration capture.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            baud_cnt <= '0;
            div_m1   <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            par_en   <= 1'b0;
            two_stop <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_set;
            if (state == S_IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
                if (handshake) begin
                    div_m1   <= div_m1_of(Baud_set);
                    last_bit <= {1'b0, Data_bits} + 3'd4;
                    data_q   <= Data;
                    parity_q <= (^(Data & payload_mask)) ^ (Parity_mode == 2'd2);
                    par_en   <= (Parity_mode == 2'd1) || (Parity_mode == 2'd2);
                    two_stop <= Stop_bits;
                end
            end else if (bit_end) begin
                baud_cnt <= '0;
                // The bit counter restarts whenever the state moves on, so it
                // indexes payload bits in DATA and stop bits in STOP.
                bit_cnt  <= (next_state != state) ? 3'd0 : bit_cnt + 3'd1;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Outputs decode from state so an asynchronous reset idles the line at once.
    assign uart_tx  = tx_line;
    assign Tx_ready = (state == S_IDLE) && !Reset;
    assign Tx_busy  = (state != S_IDLE);
    assign Tx_done  = done_q;

endmodule
